// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for the ALU issue sequencer.
package alu_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned OPW   = 8;
  localparam int unsigned FW    = 5;

  // R-type op_ext codes (op_hi = 0000)
  localparam logic [3:0] OPX_WAIT = 4'h0;
  localparam logic [3:0] OPX_AND  = 4'h1;
  localparam logic [3:0] OPX_OR   = 4'h2;
  localparam logic [3:0] OPX_XOR  = 4'h3;
  localparam logic [3:0] OPX_ADD  = 4'h5;
  localparam logic [3:0] OPX_ADDU = 4'h6;
  localparam logic [3:0] OPX_ADDC = 4'h7;
  localparam logic [3:0] OPX_SUB  = 4'h9;
  localparam logic [3:0] OPX_CMP  = 4'hB;

  // I-type op_hi codes
  localparam logic [3:0] OPH_RTYPE = 4'h0;
  localparam logic [3:0] OPH_ADDI  = 4'h5;
  localparam logic [3:0] OPH_ADDUI = 4'h6;
  localparam logic [3:0] OPH_ADDCI = 4'h7;
  localparam logic [3:0] OPH_SHIFT = 4'h8;
  localparam logic [3:0] OPH_SUBI  = 4'h9;
  localparam logic [3:0] OPH_CMPI  = 4'hB;

  // Flag bit positions within alu_flags / psr
  localparam int unsigned FLAG_Z = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Instruction word fields
  typedef struct packed {
    logic [3:0] op_hi;
    logic [3:0] rdest;
    logic [3:0] op_ext;
    logic [3:0] rsrc;
  } inst_t;

  // Decoded instruction as handed to EXEC
  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic           wr_en;
    logic           flag_en;
    logic [AW-1:0]  rdest;
  } decode_t;

  // 8-bit immediate extension: ADDUI zero-extends, all others sign-extend
  function automatic logic [DW-1:0] ext_imm(input logic [3:0] op_hi, input logic [7:0] imm);
    if (op_hi == OPH_ADDUI) return {8'h00, imm};
    else                    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile16.sv
// 16x16 register file: one write port, two operand read ports, one debug read port.
module regfile16
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a_c,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b_c,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data_c
);

  logic [DW-1:0] regs_q [NREGS];

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a_c  = regs_q[raddr_a];
  assign rdata_b_c  = regs_q[raddr_b];
  assign dbg_data_c = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue sequencer: accept, decode, execute on the external ALU, write back.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           inst_valid,
  output logic           inst_ready,
  input  logic [DW-1:0]  inst,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_c,
  input  logic [FW-1:0]  alu_flags,
  output logic [FW-1:0]  psr,
  output logic           done,
  input  logic [AW-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  state_t         state_q, state_nxt;
  inst_t          iw;
  decode_t        dec;
  logic [DW-1:0]  rd_a, rd_b;

  logic [OPW-1:0] alu_op_nxt;
  logic [DW-1:0]  alu_a_nxt, alu_b_nxt;
  logic           ready_nxt, done_nxt;
  logic [FW-1:0]  psr_nxt;
  logic [DW-1:0]  result_q, result_nxt;
  logic [FW-1:0]  flags_q, flags_nxt;
  logic           wr_en_q, wr_en_nxt;
  logic           flag_en_q, flag_en_nxt;
  logic [AW-1:0]  rdest_q, rdest_nxt;
  logic           rf_we;

  assign iw = inst_t'(inst);

  regfile16 u_rf (
    .clk        (clk),
    .rst_n      (reset_n),
    .we         (rf_we),
    .waddr      (rdest_q),
    .wdata      (result_q),
    .raddr_a    (iw.rdest),
    .rdata_a_c  (rd_a),
    .raddr_b    (iw.rsrc),
    .rdata_b_c  (rd_b),
    .dbg_addr   (dbg_addr),
    .dbg_data_c (dbg_data)
  );

  // Instruction decode from the offered word and current register contents
  always_comb begin
    dec       = '0;
    dec.rdest = iw.rdest;
    dec.a     = rd_a;
    case (iw.op_hi)
      OPH_RTYPE: begin
        dec.op = {OPH_RTYPE, iw.op_ext};
        dec.b  = rd_b;
      end
      OPH_SHIFT: begin
        dec.op = {OPH_SHIFT, iw.op_ext};
        dec.b  = {12'h000, iw.rsrc};
      end
      default: begin
        dec.op = {iw.op_hi, 4'h0};
        dec.b  = ext_imm(iw.op_hi, {iw.op_ext, iw.rsrc});
      end
    endcase
    dec.wr_en   = (dec.op != {OPH_RTYPE, OPX_CMP}) && (dec.op != {OPH_CMPI, 4'h0})
                  && (dec.op != {OPH_RTYPE, OPX_WAIT});
    dec.flag_en = (dec.op != {OPH_RTYPE, OPX_WAIT});
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state_q;
    alu_op_nxt  = '0;
    alu_a_nxt   = '0;
    alu_b_nxt   = '0;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;
    psr_nxt     = psr;
    result_nxt  = result_q;
    flags_nxt   = flags_q;
    wr_en_nxt   = wr_en_q;
    flag_en_nxt = flag_en_q;
    rdest_nxt   = rdest_q;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (inst_valid && inst_ready) begin
          state_nxt   = ST_EXEC;
          ready_nxt   = 1'b0;
          alu_op_nxt  = dec.op;
          alu_a_nxt   = dec.a;
          alu_b_nxt   = dec.b;
          wr_en_nxt   = dec.wr_en;
          flag_en_nxt = dec.flag_en;
          rdest_nxt   = dec.rdest;
        end
      end
      ST_EXEC: begin
        state_nxt  = ST_WB;
        result_nxt = alu_c;
        flags_nxt  = alu_flags;
        done_nxt   = 1'b1;
      end
      ST_WB: begin
        state_nxt = ST_IDLE;
        ready_nxt = 1'b1;
        rf_we     = wr_en_q;
        if (flag_en_q) psr_nxt = flags_q;
      end
      default: begin
        state_nxt = ST_IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      inst_ready <= 1'b1;
      done       <= 1'b0;
      psr        <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      wr_en_q    <= 1'b0;
      flag_en_q  <= 1'b0;
      rdest_q    <= '0;
    end else begin
      state_q    <= state_nxt;
      alu_op     <= alu_op_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      inst_ready <= ready_nxt;
      done       <= done_nxt;
      psr        <= psr_nxt;
      result_q   <= result_nxt;
      flags_q    <= flags_nxt;
      wr_en_q    <= wr_en_nxt;
      flag_en_q  <= flag_en_nxt;
      rdest_q    <= rdest_nxt;
    end
  end

endmodule
